// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard unit.
// The datapath drives the hazard inputs; the hazard unit returns the per-stage control codes.
interface hazard_unit_if;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [3:0]  ex_rd;
    logic        ex_mem_read;
    logic        branch_taken;
    logic        mem_busy;

    logic [1:0]  pc_nop;
    logic [1:0]  ifid_nop;
    logic [1:0]  idex_nop;
    logic [1:0]  exmem_nop;
    logic [1:0]  memwb_nop;
    logic [15:0] stall_cycles;

    // Debug view of the controller: state encoding and remaining-cycle counter
    logic [1:0]  state_dbg;
    logic [2:0]  cnt_dbg;

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               branch_taken, mem_busy,
        output pc_nop, ifid_nop, idex_nop, exmem_nop, memwb_nop, stall_cycles,
               state_dbg, cnt_dbg
    );

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               branch_taken, mem_busy,
        input  pc_nop, ifid_nop, idex_nop, exmem_nop, memwb_nop, stall_cycles,
               state_dbg, cnt_dbg
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and memory-wait holds.
// Control codes are combinational from state and inputs; state, cnt and stall_cycles are registered.
module hazard_unit #(
    parameter int unsigned BRANCH_PENALTY    = 2,
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input logic          clk,
    input logic          reset,
    hazard_unit_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [1:0] UPD    = 2'b00;
    localparam logic [1:0] HOLD   = 2'b01;
    localparam logic [1:0] BUBBLE = 2'b10;

    localparam logic [2:0] BR_CNT = 3'(BRANCH_PENALTY - 1);
    localparam logic [2:0] LS_CNT = 3'(LOAD_STALL_CYCLES - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [15:0] stall_cycles;

    logic        luh;
    logic        branch_act;
    logic [1:0]  pc_nop;
    logic [1:0]  ifid_nop;
    logic [1:0]  idex_nop;
    logic [1:0]  exmem_nop;
    logic [1:0]  memwb_nop;

    assign luh = bus.ex_mem_read && (bus.ex_rd != 4'd0) &&
                 ((bus.id_use_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                  (bus.id_use_rs2 && (bus.ex_rd == bus.id_rs2)));

    // A branch seen during FLUSH is already covered by the flush in progress
    assign branch_act = bus.branch_taken && (state != FLUSH);

    always_comb begin
        pc_nop    = UPD;
        ifid_nop  = UPD;
        idex_nop  = UPD;
        exmem_nop = UPD;
        memwb_nop = UPD;
        if (reset) begin
            ifid_nop  = BUBBLE;
            idex_nop  = BUBBLE;
            exmem_nop = BUBBLE;
            memwb_nop = BUBBLE;
        end else if (bus.mem_busy) begin
            pc_nop    = HOLD;
            ifid_nop  = HOLD;
            idex_nop  = HOLD;
            exmem_nop = HOLD;
            memwb_nop = BUBBLE;
        end else if (branch_act) begin
            ifid_nop  = BUBBLE;
            idex_nop  = BUBBLE;
        end else if (state == FLUSH) begin
            pc_nop    = HOLD;
            ifid_nop  = BUBBLE;
            idex_nop  = BUBBLE;
        end else if (luh || (state == STALL)) begin
            pc_nop    = HOLD;
            ifid_nop  = HOLD;
            idex_nop  = BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= 3'd0;
            stall_cycles <= 16'd0;
        end else begin
            // mem_busy freezes the sequencer entirely
            if (!bus.mem_busy) begin
                if (branch_act) begin
                    state <= (BR_CNT != 3'd0) ? FLUSH : RUN;
                    cnt   <= BR_CNT;
                end else if (state == FLUSH || state == STALL) begin
                    if (cnt <= 3'd1) begin
                        state <= RUN;
                        cnt   <= 3'd0;
                    end else begin
                        cnt   <= cnt - 3'd1;
                    end
                end else if (luh) begin
                    state <= (LS_CNT != 3'd0) ? STALL : RUN;
                    cnt   <= LS_CNT;
                end
            end
            if (pc_nop == HOLD && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

    assign bus.pc_nop       = pc_nop;
    assign bus.ifid_nop     = ifid_nop;
    assign bus.idex_nop     = idex_nop;
    assign bus.exmem_nop    = exmem_nop;
    assign bus.memwb_nop    = memwb_nop;
    assign bus.stall_cycles = stall_cycles;
    assign bus.state_dbg    = state;
    assign bus.cnt_dbg      = cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (BP=2/LSC=1 and BP=1/LSC=3) share one stimulus stream.
// Expected control vectors {pc,ifid,idex,exmem,memwb} are queued per cycle and compared mid-cycle.
module tb_hazard_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, branch_taken, mem_busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    string       cur_test = "init";
    logic [10:0] exp_q[$];

    localparam logic [9:0] V_RST  = 10'b00_10_10_10_10;
    localparam logic [9:0] V_NORM = 10'b00_00_00_00_00;
    localparam logic [9:0] V_BR   = 10'b00_10_10_00_00;
    localparam logic [9:0] V_FL   = 10'b01_10_10_00_00;
    localparam logic [9:0] V_LU   = 10'b01_01_10_00_00;
    localparam logic [9:0] V_MB   = 10'b01_01_01_01_10;

    always #5 clk = ~clk;

    hazard_unit_if ifa();
    hazard_unit_if ifb();

    assign ifa.id_rs1 = id_rs1;             assign ifb.id_rs1 = id_rs1;
    assign ifa.id_rs2 = id_rs2;             assign ifb.id_rs2 = id_rs2;
    assign ifa.id_use_rs1 = id_use_rs1;     assign ifb.id_use_rs1 = id_use_rs1;
    assign ifa.id_use_rs2 = id_use_rs2;     assign ifb.id_use_rs2 = id_use_rs2;
    assign ifa.ex_rd = ex_rd;               assign ifb.ex_rd = ex_rd;
    assign ifa.ex_mem_read = ex_mem_read;   assign ifb.ex_mem_read = ex_mem_read;
    assign ifa.branch_taken = branch_taken; assign ifb.branch_taken = branch_taken;
    assign ifa.mem_busy = mem_busy;         assign ifb.mem_busy = mem_busy;

    hazard_unit #(.BRANCH_PENALTY(2), .LOAD_STALL_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );
    hazard_unit #(.BRANCH_PENALTY(1), .LOAD_STALL_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    wire [9:0] out_a = {ifa.pc_nop, ifa.ifid_nop, ifa.idex_nop, ifa.exmem_nop, ifa.memwb_nop};
    wire [9:0] out_b = {ifb.pc_nop, ifb.ifid_nop, ifb.idex_nop, ifb.exmem_nop, ifb.memwb_nop};

    task automatic set_in(input logic r, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic u1, input logic u2, input logic [3:0] rd,
                          input logic mr, input logic br, input logic mb);
        reset = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; branch_taken = br; mem_busy = mb;
    endtask

    // One clock: queue the expected vector, pop and compare mid-cycle, then cross the edge.
    task automatic cycle(input logic [9:0] exp, input logic use_b);
        logic [10:0] e;
        logic [9:0]  got;
        exp_q.push_back({use_b, exp});
        @(negedge clk);
        e   = exp_q.pop_front();
        got = e[10] ? out_b : out_a;
        n_checks++;
        if (got === e[9:0]) n_pass++;
        else $display("FAIL %s dut_%s ctrl got=%b exp=%b", cur_test, e[10] ? "b" : "a", got, e[9:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic use_b);
        set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        cycle(V_RST, use_b);
    endtask

    task automatic set_idle();
        set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_cnt(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s %s got=%0d exp=%0d", cur_test, name, got, exp);
    endtask

    task automatic test_reset();
        cur_test = "reset";
        // Dirty inputs during reset must be ignored
        set_in(1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1);
        cycle(V_RST, 1'b0);
        cycle(V_RST, 1'b1);
        check_cnt("stall_a", ifa.stall_cycles, 16'd0);
        check_cnt("state_a", {14'd0, ifa.state_dbg}, 16'd0);
        set_idle();
        cycle(V_NORM, 1'b0);
    endtask

    task automatic test_load_use();
        cur_test = "load_use";
        do_reset(1'b0);
        set_in(1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
        cycle(V_LU, 1'b0);
        set_idle();
        cycle(V_NORM, 1'b0);
        check_cnt("stall_a", ifa.stall_cycles, 16'd1);
        // rs2 path
        set_in(1'b0, 4'd1, 4'd9, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        cycle(V_LU, 1'b0);
        // Matching rs2 that is not actually read
        set_in(1'b0, 4'd1, 4'd9, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
        cycle(V_NORM, 1'b0);
        // Match but EX is not a load
        set_in(1'b0, 4'd9, 4'd0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
        cycle(V_NORM, 1'b0);
        check_cnt("stall_a2", ifa.stall_cycles, 16'd2);
    endtask

    task automatic test_rd_zero();
        cur_test = "rd_zero";
        do_reset(1'b0);
        set_in(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        cycle(V_NORM, 1'b0);
        check_cnt("stall_a", ifa.stall_cycles, 16'd0);
    endtask

    task automatic test_random_luh();
        int hits = 0;
        logic [3:0] rs1, rs2, rd;
        logic u1, u2, mr, h;
        cur_test = "random_luh";
        do_reset(1'b0);
        for (int i = 0; i < 40; i++) begin
            rs1 = 4'($urandom_range(0, 3)); rs2 = 4'($urandom_range(0, 3));
            rd  = 4'($urandom_range(0, 3));
            u1  = 1'($urandom_range(0, 1)); u2 = 1'($urandom_range(0, 1));
            mr  = 1'($urandom_range(0, 1));
            h = mr && (rd != 4'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
            if (h) hits++;
            set_in(1'b0, rs1, rs2, u1, u2, rd, mr, 1'b0, 1'b0);
            cycle(h ? V_LU : V_NORM, 1'b0);
        end
        check_cnt("stall_a", ifa.stall_cycles, 16'(hits));
    endtask

    task automatic test_branch();
        cur_test = "branch";
        do_reset(1'b0);
        set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cycle(V_BR, 1'b0);
        set_idle();
        cycle(V_FL, 1'b0);
        cycle(V_NORM, 1'b0);
        check_cnt("stall_a", ifa.stall_cycles, 16'd1);
        // Penalty of 1: no FLUSH cycle
        cur_test = "branch_bp1";
        do_reset(1'b1);
        set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cycle(V_BR, 1'b1);
        set_idle();
        cycle(V_NORM, 1'b1);
        check_cnt("stall_b", ifb.stall_cycles, 16'd0);
    endtask

    task automatic test_mem_busy_flush();
        cur_test = "mem_busy_flush";
        do_reset(1'b0);
        set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cycle(V_BR, 1'b0);
        // Branch and load-use while busy are ignored
        set_in(1'b0, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(V_MB, 1'b0);
        set_idle();
        cycle(V_FL, 1'b0);
        cycle(V_NORM, 1'b0);
        check_cnt("stall_a", ifa.stall_cycles, 16'd4);
    endtask

    task automatic test_luh_and_branch();
        cur_test = "luh_and_branch";
        do_reset(1'b0);
        set_in(1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        cycle(V_BR, 1'b0);
        check_cnt("stall_a0", ifa.stall_cycles, 16'd0);
        set_idle();
        cycle(V_FL, 1'b0);
        cycle(V_NORM, 1'b0);
        check_cnt("stall_a1", ifa.stall_cycles, 16'd1);
    endtask

    task automatic test_long_stall();
        cur_test = "long_stall";
        do_reset(1'b1);
        set_in(1'b0, 4'd7, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
        cycle(V_LU, 1'b1);
        set_idle();
        cycle(V_LU, 1'b1);
        cycle(V_LU, 1'b1);
        cycle(V_NORM, 1'b1);
        check_cnt("stall_b", ifb.stall_cycles, 16'd3);
        cur_test = "branch_in_stall";
        do_reset(1'b1);
        set_in(1'b0, 4'd7, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
        cycle(V_LU, 1'b1);
        set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cycle(V_BR, 1'b1);
        set_idle();
        cycle(V_NORM, 1'b1);
        check_cnt("stall_b2", ifb.stall_cycles, 16'd1);
    endtask

    task automatic test_reset_in_stall();
        cur_test = "reset_in_stall";
        do_reset(1'b1);
        set_in(1'b0, 4'd7, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
        cycle(V_LU, 1'b1);
        set_idle();
        cycle(V_LU, 1'b1);
        do_reset(1'b1);
        set_idle();
        cycle(V_NORM, 1'b1);
        check_cnt("stall_b", ifb.stall_cycles, 16'd0);
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        do_reset(1'b0);
        set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cycle(V_BR, 1'b0);
        set_idle();
        cycle(V_FL, 1'b0);
        set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cycle(V_BR, 1'b0);
        set_idle();
        cycle(V_FL, 1'b0);
        set_in(1'b0, 4'd2, 4'd2, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        cycle(V_LU, 1'b0);
        cycle(V_LU, 1'b0);
        cycle(V_LU, 1'b0);
        set_idle();
        cycle(V_NORM, 1'b0);
        check_cnt("stall_a", ifa.stall_cycles, 16'd5);
    endtask

    task automatic test_saturation();
        cur_test = "saturation";
        do_reset(1'b0);
        set_in(1'b0, 4'd4, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check_cnt("stall_a10", ifa.stall_cycles, 16'd10);
        repeat (65530) @(posedge clk);
        #1;
        check_cnt("stall_sat", ifa.stall_cycles, 16'hFFFF);
        set_idle();
        cycle(V_NORM, 1'b0);
        check_cnt("stall_hold", ifa.stall_cycles, 16'hFFFF);
    endtask

    initial begin
        set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_rd_zero();
        test_random_luh();
        test_branch();
        test_mem_busy_flush();
        test_luh_and_branch();
        test_long_stall();
        test_reset_in_stall();
        test_back_to_back();
        test_saturation();
        cur_test = "final";
        check_cnt("queue_left", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
